// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and counter-width helper shared by the debouncer files.
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/stable_timer.sv
// stable_timer: saturating qualification counter; done marks STABLE_CYCLES-1 consecutive enables.
module stable_timer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !done) cnt <= cnt + 1'b1;
  assign done = cnt == CW'(STABLE_CYCLES - 1);
endmodule

// File: rtl/debounce_edge_fsm.sv
// debounce_edge_fsm: synchronise a noisy pin, qualify each level change with a stability timer,
// and emit a registered clean level with one-cycle rise/fall strobes.
module debounce_edge_fsm
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 255,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy_in,
  output logic db_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync_in, clear, enable, done, db_n, rise_n, fall_n;
  state_t state, state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
  assign sync_in = sync_q[SYNC_STAGES-1];
  stable_timer #(.STABLE_CYCLES(STABLE_CYCLES)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .enable (enable),
    .done   (done)
  );
  // Timer is held clear outside WAIT and whenever a candidate is aborted or accepted.
  always_comb begin
    state_n = IDLE_LOW;
    clear   = 1'b1;
    enable  = 1'b0;
    db_n    = 1'b0;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      IDLE_LOW:  state_n = sync_in ? WAIT_HIGH : IDLE_LOW;
      WAIT_HIGH: begin
        state_n = !sync_in ? IDLE_LOW : done ? IDLE_HIGH : WAIT_HIGH;
        enable  = sync_in && !done;
        clear   = !enable;
        rise_n  = sync_in && done;
        db_n    = rise_n;
      end
      IDLE_HIGH: begin
        state_n = sync_in ? IDLE_HIGH : WAIT_LOW;
        db_n    = 1'b1;
      end
      WAIT_LOW:  begin
        state_n = sync_in ? IDLE_HIGH : done ? IDLE_LOW : WAIT_LOW;
        enable  = !sync_in && !done;
        clear   = !enable;
        fall_n  = !sync_in && done;
        db_n    = !fall_n;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE_LOW;
      db_level   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      db_level   <= db_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
      busy       <= (state_n == WAIT_HIGH) || (state_n == WAIT_LOW);
    end
endmodule

// File: tb/tb_debounce_edge_fsm.sv
// tb_debounce_edge_fsm: directed scenarios plus random bounce checked against a sliding-window model.
module tb_debounce_edge_fsm;
  logic clk = 1'b0, reset_n = 1'b0, noisy_in = 1'b0;
  logic db_level, rise_pulse, fall_pulse, busy;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  debounce_edge_fsm #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .noisy_in  (noisy_in),
    .db_level  (db_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );
  // Reference: the level flips once the last five synchronised samples agree; the synchroniser
  // delays each pin sample by two edges, so the window is pin samples e-6..e-2 at edge e.
  logic [5:0] h;
  logic db_m, rise_m, fall_m, busy_m;
  function automatic logic nd(input logic [4:0] w, input logic d);
    return (&w) ? 1'b1 : (~|w) ? 1'b0 : d;
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h <= '0; db_m <= 1'b0; rise_m <= 1'b0; fall_m <= 1'b0; busy_m <= 1'b0;
    end else begin
      h      <= {h[4:0], noisy_in};
      db_m   <= nd(h[5:1], db_m);
      rise_m <= nd(h[5:1], db_m) & ~db_m;
      fall_m <= ~nd(h[5:1], db_m) & db_m;
      busy_m <= h[1] ^ nd(h[5:1], db_m);
    end
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      noisy_in = v;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    drive(1'b0, 3);
    vectors++;
    if ({db_level, rise_pulse, fall_pulse, busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_hold got=%b exp=0000", {db_level, rise_pulse, fall_pulse, busy});
    end
    reset_n = 1'b1;
    drive(1'b0, 8);
    drive(1'b1, 3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_high_busy got=%b exp=1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({db_level, rise_pulse, fall_pulse, busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid_wait got=%b exp=0000", {db_level, rise_pulse, fall_pulse, busy});
    end
    noisy_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1);
      vectors++;
      if ({db_level, rise_pulse, fall_pulse, busy} !== 4'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc=%0d got=%b exp=0000", i,
                 {db_level, rise_pulse, fall_pulse, busy});
      end
    end
  endtask
  task automatic test_clean_rise;
    logic [3:0] exp;
    int busy_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1);
      exp = {i >= 7, i == 7, 1'b0, i >= 3 && i <= 6};
      busy_cnt += int'(busy);
      vectors++;
      if ({db_level, rise_pulse, fall_pulse, busy} !== exp) begin
        miscompares++;
        $display("FAIL clean_rise cyc=%0d got=%b exp=%b", i,
                 {db_level, rise_pulse, fall_pulse, busy}, exp);
      end
    end
    vectors++;
    if (busy_cnt != 4) begin
      miscompares++;
      $display("FAIL clean_rise_busy_cycles got=%0d exp=4", busy_cnt);
    end
    drive(1'b0, 12);
  endtask
  task automatic test_boundary;
    int seen_busy = 0, rises = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(i <= 4, 1);
      seen_busy += int'(busy);
      vectors++;
      if ({db_level, rise_pulse, fall_pulse} !== 3'b0) begin
        miscompares++;
        $display("FAIL boundary_reject cyc=%0d got=%b exp=000", i,
                 {db_level, rise_pulse, fall_pulse});
      end
    end
    vectors++;
    if (busy !== 1'b0 || seen_busy != 4) begin
      miscompares++;
      $display("FAIL boundary_busy got=%b/%0d exp=0/4", busy, seen_busy);
    end
    for (int i = 1; i <= 17; i++) begin
      drive(i <= 5, 1);
      rises += int'(rise_pulse);
      vectors++;
      if ({db_level, rise_pulse, fall_pulse, busy} !== {db_m, rise_m, fall_m, busy_m}) begin
        miscompares++;
        $display("FAIL boundary_accept cyc=%0d got=%b exp=%b", i,
                 {db_level, rise_pulse, fall_pulse, busy}, {db_m, rise_m, fall_m, busy_m});
      end
    end
    vectors++;
    if (rises != 1) begin
      miscompares++;
      $display("FAIL boundary_rise_count got=%0d exp=1", rises);
    end
  endtask
  task automatic test_bounce;
    logic [15:0] pat = 16'b0000_0000_0000_0100;
    logic [2:0] exp;
    drive(1'b1, 12);
    vectors++;
    if (db_level !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_start_high got=%b exp=1", db_level);
    end
    for (int i = 1; i <= 16; i++) begin
      drive(pat[i-1], 1);
      exp = {i < 10, 1'b0, i == 10};
      vectors++;
      if ({db_level, rise_pulse, fall_pulse} !== exp) begin
        miscompares++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", i, {db_level, rise_pulse, fall_pulse}, exp);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0] exp;
    drive(1'b0, 12);
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 1);
      exp = {i >= 7, i == 7, 1'b0, i >= 3 && i <= 6};
      vectors++;
      if ({db_level, rise_pulse, fall_pulse, busy} !== exp) begin
        miscompares++;
        $display("FAIL b2b_rise cyc=%0d got=%b exp=%b", i,
                 {db_level, rise_pulse, fall_pulse, busy}, exp);
      end
    end
    for (int j = 1; j <= 10; j++) begin
      drive(1'b0, 1);
      exp = {j < 7, 1'b0, j == 7, j >= 3 && j <= 6};
      vectors++;
      if ({db_level, rise_pulse, fall_pulse, busy} !== exp) begin
        miscompares++;
        $display("FAIL b2b_fall cyc=%0d got=%b exp=%b", j,
                 {db_level, rise_pulse, fall_pulse, busy}, exp);
      end
    end
  endtask
  task automatic test_random_bounce;
    logic lvl = 1'($urandom_range(1, 0));
    logic prev = db_level;
    int cyc = 0, run = 0, ups = 0, downs = 0, rises = 0, falls = 0;
    while (cyc < 1000) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(8, 1);
      end
      drive(lvl, 1);
      run--;
      cyc++;
      rises += int'(rise_pulse);
      falls += int'(fall_pulse);
      ups   += int'(db_level && !prev);
      downs += int'(!db_level && prev);
      prev  = db_level;
      vectors++;
      if ({db_level, rise_pulse, fall_pulse, busy} !== {db_m, rise_m, fall_m, busy_m}) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                 {db_level, rise_pulse, fall_pulse, busy}, {db_m, rise_m, fall_m, busy_m});
      end
    end
    vectors++;
    if (rises != ups || falls != downs) begin
      miscompares++;
      $display("FAIL random_pulse_counts rise=%0d/%0d fall=%0d/%0d", rises, ups, falls, downs);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_clean_rise;
    test_boundary;
    test_bounce;
    test_back_to_back;
    test_random_bounce;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
